// File: rtl/apx_float_accum_ctrl.sv
// -----------------------------------------------------------------------------
// apx_float_accum_ctrl
//
// Sequencer that sums groups of N_TERMS IEEE-754 single-precision samples using
// an external handshaked float adder. Each sample is fed to the adder together
// with the running sum. After N_TERMS adder results the final sum is presented
// on the output channel. Once it is taken, the sum and the term count start
// again from zero.
//
// Every channel uses a stb/ack handshake: a transfer happens on a rising edge
// where both are high. All channel outputs are registered. They are decoded
// from the next state, so a strobe or ack drops on the same edge as its
// transfer.
//
// Parameters
//   N_TERMS      samples summed per result (1..65535)
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset
//   in_data/in_stb/in_ack            sample input channel
//   adder_a/adder_a_stb/adder_a_ack  running sum to the adder
//   adder_b/adder_b_stb/adder_b_ack  current sample to the adder
//   adder_z/adder_z_stb/adder_z_ack  adder result
//   out_sum/out_stb/out_ack          finished sum output channel
//
// Build option
//   APX_ACC_NAN_ABORT_EN  when defined, a NaN adder result forces the sum to
//                         the canonical quiet NaN. The remaining samples of that
//                         group are accepted and counted but not sent to the
//                         adder.
// -----------------------------------------------------------------------------
module apx_float_accum_ctrl #(
  parameter int N_TERMS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_stb,
  output logic        in_ack,
  output logic [31:0] adder_a,
  output logic        adder_a_stb,
  input  logic        adder_a_ack,
  output logic [31:0] adder_b,
  output logic        adder_b_stb,
  input  logic        adder_b_ack,
  input  logic [31:0] adder_z,
  input  logic        adder_z_stb,
  output logic        adder_z_ack,
  output logic [31:0] out_sum,
  output logic        out_stb,
  input  logic        out_ack
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_TERMS);

  typedef enum logic [2:0] {
    GET_X,
    SEND_A,
    SEND_B,
    WAIT_Z,
    PUT_SUM
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   acc, acc_nxt;
  logic [DATA_W-1:0]   sample;
  logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;

  logic                in_ack_nxt, a_stb_nxt, b_stb_nxt, z_ack_nxt, out_stb_nxt;
  logic [DATA_W-1:0]   adder_a_nxt, adder_b_nxt, out_sum_nxt;

  logic                in_xfer, a_xfer, b_xfer, z_xfer, out_xfer;
  // High while a NaN has poisoned the current group and samples bypass the adder.
  logic                skip;

  assign in_xfer  = in_stb & in_ack;
  assign a_xfer   = adder_a_stb & adder_a_ack;
  assign b_xfer   = adder_b_stb & adder_b_ack;
  assign z_xfer   = adder_z_stb & adder_z_ack;
  assign out_xfer = out_stb & out_ack;
  assign cnt_inc  = cnt + 1'b1;

`ifdef APX_ACC_NAN_ABORT_EN
  localparam logic [DATA_W-1:0] QNAN = 32'hFFC0_0000;

  logic abort, abort_nxt;

  function automatic logic is_nan(input logic [DATA_W-1:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  assign skip = abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      abort <= 1'b0;
    end else begin
      abort <= abort_nxt;
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
`ifdef APX_ACC_NAN_ABORT_EN
    abort_nxt = abort;
`endif
    case (state)
      GET_X: begin
        if (in_xfer) begin
          if (skip) begin
            // Poisoned group: count the sample and drop it.
            cnt_nxt   = cnt_inc;
            state_nxt = (cnt_inc == N_LAST) ? PUT_SUM : GET_X;
          end else begin
            state_nxt = SEND_A;
          end
        end
      end
      SEND_A: begin
        if (a_xfer) state_nxt = SEND_B;
      end
      SEND_B: begin
        if (b_xfer) state_nxt = WAIT_Z;
      end
      WAIT_Z: begin
        if (z_xfer) begin
          acc_nxt = adder_z;
`ifdef APX_ACC_NAN_ABORT_EN
          if (is_nan(adder_z)) begin
            acc_nxt   = QNAN;
            abort_nxt = 1'b1;
          end
`endif
          cnt_nxt   = cnt_inc;
          state_nxt = (cnt_inc == N_LAST) ? PUT_SUM : GET_X;
        end
      end
      PUT_SUM: begin
        if (out_xfer) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
`ifdef APX_ACC_NAN_ABORT_EN
          abort_nxt = 1'b0;
`endif
          state_nxt = GET_X;
        end
      end
      default: state_nxt = GET_X;
    endcase

    // Registered outputs follow the state being entered. in_ack also drops for
    // one cycle after a transfer that stays in GET_X (poisoned group).
    in_ack_nxt  = (state_nxt == GET_X) && !in_xfer;
    a_stb_nxt   = (state_nxt == SEND_A);
    b_stb_nxt   = (state_nxt == SEND_B);
    z_ack_nxt   = (state_nxt == WAIT_Z);
    out_stb_nxt = (state_nxt == PUT_SUM);
    adder_a_nxt = (state_nxt == SEND_A)  ? acc_nxt : '0;
    adder_b_nxt = (state_nxt == SEND_B)  ? sample  : '0;
    out_sum_nxt = (state_nxt == PUT_SUM) ? acc_nxt : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= GET_X;
      acc         <= '0;
      cnt         <= '0;
      in_ack      <= 1'b0;
      adder_a_stb <= 1'b0;
      adder_b_stb <= 1'b0;
      adder_z_ack <= 1'b0;
      out_stb     <= 1'b0;
      adder_a     <= '0;
      adder_b     <= '0;
      out_sum     <= '0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      cnt         <= cnt_nxt;
      in_ack      <= in_ack_nxt;
      adder_a_stb <= a_stb_nxt;
      adder_b_stb <= b_stb_nxt;
      adder_z_ack <= z_ack_nxt;
      out_stb     <= out_stb_nxt;
      adder_a     <= adder_a_nxt;
      adder_b     <= adder_b_nxt;
      out_sum     <= out_sum_nxt;
    end
  end

  // The sample holder needs no reset: it only reaches adder_b after a fresh load.
  always_ff @(posedge clk) begin
    if (in_xfer && !skip) sample <= in_data;
  end

endmodule
